// File: rtl/data_ram_arb_pkg.sv
// Shared types and helpers for the data RAM arbiter.
// The state enum, owner encodings and byte-strobe to bit-mask expansion live here.
package data_ram_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Expand a 4-bit byte strobe into a 32-bit mask, one byte of ones per set strobe bit
  function automatic logic [31:0] strb2mask(input logic [3:0] wstrb);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{wstrb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_picker.sv
// Two-way round-robin picker for the data RAM arbiter.
// A lone requester always wins. When both request, the port that was not
// served last wins.
module dram_rr_picker
  import data_ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_owner,
  output logic       o_valid
);

  // Choose the winner for this cycle from the request pair and the last-served port
  always_comb begin
    o_valid = |i_req;
    o_owner = M0;
    if (i_req == 2'b11) begin
      o_owner = ~i_last;
    end else if (i_req[1]) begin
      o_owner = M1;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Arbiter sharing one single-port, word-addressed data RAM between the CPU
// data port (m0) and the loader/debug port (m1).
// Every access takes an IDLE cycle, where the owner is chosen, followed by an
// ACCESS cycle, where it is granted. Partial stores are merged with the
// asynchronous RAM read data in the same ACCESS cycle.
// Optional build macro: DATA_RAM_ARB_PERF_EN adds grant and conflict counters.
module data_ram_arbiter
  import data_ram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,

  input  logic                 i_m0_req,
  input  logic                 i_m0_we,
  input  logic [3:0]           i_m0_wstrb,
  input  logic [ADDR_BITS-1:0] i_m0_addr,
  input  logic [31:0]          i_m0_wdata,
  output logic                 o_m0_gnt,
  output logic                 o_m0_rvalid,
  output logic [31:0]          o_m0_rdata,

  input  logic                 i_m1_req,
  input  logic                 i_m1_we,
  input  logic [3:0]           i_m1_wstrb,
  input  logic [ADDR_BITS-1:0] i_m1_addr,
  input  logic [31:0]          i_m1_wdata,
  output logic                 o_m1_gnt,
  output logic                 o_m1_rvalid,
  output logic [31:0]          o_m1_rdata,

  output logic [ADDR_BITS-1:0] o_ram_a,
  output logic                 o_ram_we,
  output logic [31:0]          o_ram_d,
  input  logic [31:0]          i_ram_spo
`ifdef DATA_RAM_ARB_PERF_EN
  ,
  output logic [31:0]          o_perf_m0_acc,
  output logic [31:0]          o_perf_m1_acc,
  output logic [31:0]          o_perf_conflict
`endif
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_owner;
  logic                   r_last;
  logic                   r_m0_rvalid;
  logic                   r_m1_rvalid;
  logic [31:0]            r_m0_rdata;
  logic [31:0]            r_m1_rdata;

  logic                   w_pick_owner;
  logic                   w_pick_valid;
  logic                   w_access;
  logic                   w_own_we;
  logic [3:0]             w_own_wstrb;
  logic [ADDR_BITS-1:0]   w_own_addr;
  logic [31:0]            w_own_wdata;
  logic [31:0]            w_mask;

  dram_rr_picker u_picker (
    .i_req   ({i_m1_req, i_m0_req}),
    .i_last  (r_last),
    .o_owner (w_pick_owner),
    .o_valid (w_pick_valid)
  );

  // Route the current owner's request fields; inputs are used live so a late drop of req still completes
  always_comb begin
    w_own_we    = i_m0_we;
    w_own_wstrb = i_m0_wstrb;
    w_own_addr  = i_m0_addr;
    w_own_wdata = i_m0_wdata;
    if (r_owner == M1) begin
      w_own_we    = i_m1_we;
      w_own_wstrb = i_m1_wstrb;
      w_own_addr  = i_m1_addr;
      w_own_wdata = i_m1_wdata;
    end
  end

  assign w_mask   = strb2mask(w_own_wstrb);
  assign w_access = (r_state == ACCESS) && i_rst_n;

  // Next-state logic and the RAM/grant outputs driven during the ACCESS cycle
  always_comb begin
    w_next_state = r_state;
    o_m0_gnt     = 1'b0;
    o_m1_gnt     = 1'b0;
    o_ram_a      = '0;
    o_ram_we     = 1'b0;
    o_ram_d      = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        w_next_state = IDLE;
        o_m0_gnt     = w_access && (r_owner == M0);
        o_m1_gnt     = w_access && (r_owner == M1);
        o_ram_a      = w_own_addr;
        o_ram_we     = w_access && w_own_we && (w_own_wstrb != 4'h0);
        if (w_own_we) begin
          o_ram_d = (i_ram_spo & ~w_mask) | (w_own_wdata & w_mask);
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the winner in IDLE and remember who was served at the end of ACCESS
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_owner <= M0;
      r_last  <= M1;
    end else begin
      if (r_state == IDLE && w_pick_valid) begin
        r_owner <= w_pick_owner;
      end
      if (r_state == ACCESS) begin
        r_last <= r_owner;
      end
    end
  end

  // Capture load data at the end of ACCESS and pulse rvalid in the following cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= (r_state == ACCESS) && !w_own_we && (r_owner == M0);
      r_m1_rvalid <= (r_state == ACCESS) && !w_own_we && (r_owner == M1);
      if (r_state == ACCESS && !w_own_we && r_owner == M0) begin
        r_m0_rdata <= i_ram_spo;
      end
      if (r_state == ACCESS && !w_own_we && r_owner == M1) begin
        r_m1_rdata <= i_ram_spo;
      end
    end
  end

  assign o_m0_rvalid = r_m0_rvalid;
  assign o_m1_rvalid = r_m1_rvalid;
  assign o_m0_rdata  = r_m0_rdata;
  assign o_m1_rdata  = r_m1_rdata;

`ifdef DATA_RAM_ARB_PERF_EN
  logic [31:0] r_perf_m0_acc;
  logic [31:0] r_perf_m1_acc;
  logic [31:0] r_perf_conflict;

  // Count grants per port and IDLE cycles in which both ports compete
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_perf_m0_acc   <= '0;
      r_perf_m1_acc   <= '0;
      r_perf_conflict <= '0;
    end else begin
      if (o_m0_gnt) begin
        r_perf_m0_acc <= r_perf_m0_acc + 32'd1;
      end
      if (o_m1_gnt) begin
        r_perf_m1_acc <= r_perf_m1_acc + 32'd1;
      end
      if (r_state == IDLE && i_m0_req && i_m1_req) begin
        r_perf_conflict <= r_perf_conflict + 32'd1;
      end
    end
  end

  assign o_perf_m0_acc   = r_perf_m0_acc;
  assign o_perf_m1_acc   = r_perf_m1_acc;
  assign o_perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter: directed scenarios followed by random
// two-port traffic, checked against a transaction-level model of the RAM and
// of the round-robin service order.
// Build with DATA_RAM_ARB_PERF_EN defined to also check the counters.
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstN;

  logic        reqV   [2];
  logic        weV    [2];
  logic [3:0]  strbV  [2];
  logic [15:0] addrV  [2];
  logic [31:0] wdataV [2];

  logic        m0Gnt, m1Gnt, m0Rvalid, m1Rvalid;
  logic [31:0] m0Rdata, m1Rdata;
  logic [15:0] ramA;
  logic        ramWe;
  logic [31:0] ramD;
  logic [31:0] ramSpo;
`ifdef DATA_RAM_ARB_PERF_EN
  logic [31:0] perfM0, perfM1, perfConf;
`endif

  logic [31:0] tbMem  [0:65535];
  logic [31:0] refMem [0:65535];
  logic        pokeEn;
  logic [15:0] pokeAddr;
  logic [31:0] pokeData;

  int compared   = 0;
  int mismatched = 0;

  bit          mSlot;
  bit          mOwner;
  bit          mLast;
  bit          rvPend  [2];
  logic [31:0] held    [2];
  bit          granted [2];
  int          waitCyc [2];
  int          maxWait;
  int          mdlAcc  [2];
  int          mdlConf;

  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDR_BITS(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_m0_req    (reqV[0]),
    .i_m0_we     (weV[0]),
    .i_m0_wstrb  (strbV[0]),
    .i_m0_addr   (addrV[0]),
    .i_m0_wdata  (wdataV[0]),
    .o_m0_gnt    (m0Gnt),
    .o_m0_rvalid (m0Rvalid),
    .o_m0_rdata  (m0Rdata),
    .i_m1_req    (reqV[1]),
    .i_m1_we     (weV[1]),
    .i_m1_wstrb  (strbV[1]),
    .i_m1_addr   (addrV[1]),
    .i_m1_wdata  (wdataV[1]),
    .o_m1_gnt    (m1Gnt),
    .o_m1_rvalid (m1Rvalid),
    .o_m1_rdata  (m1Rdata),
    .o_ram_a     (ramA),
    .o_ram_we    (ramWe),
    .o_ram_d     (ramD),
    .i_ram_spo   (ramSpo)
`ifdef DATA_RAM_ARB_PERF_EN
    ,
    .o_perf_m0_acc   (perfM0),
    .o_perf_m1_acc   (perfM1),
    .o_perf_conflict (perfConf)
`endif
  );

  // The RAM itself: asynchronous read, write on the clock edge, plus a poke port for preloading
  assign ramSpo = tbMem[ramA];

  initial begin
    for (int i = 0; i < 65536; i++) tbMem[i] = {i[15:0], ~i[15:0]};
    forever begin
      @(posedge clk);
      if (ramWe) tbMem[ramA] <= ramD;
      else if (pokeEn) tbMem[pokeAddr] <= pokeData;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic resetModel();
    mSlot = 0; mOwner = 0; mLast = 1;
    for (int p = 0; p < 2; p++) begin
      rvPend[p] = 0; held[p] = '0; granted[p] = 0; waitCyc[p] = 0;
      mdlAcc[p] = 0;
    end
    mdlConf = 0;
  endtask

  // Called at the falling edge: compare this cycle's outputs, then advance the model one cycle
  task automatic checkCycle();
    bit          newRv [2];
    logic [31:0] newData;
    int          p;
    checkOutput("m0_gnt", {31'd0, m0Gnt}, {31'd0, rstN && mSlot && mOwner == 0});
    checkOutput("m1_gnt", {31'd0, m1Gnt}, {31'd0, rstN && mSlot && mOwner == 1});
    checkOutput("m0_rvalid", {31'd0, m0Rvalid}, {31'd0, rvPend[0]});
    checkOutput("m1_rvalid", {31'd0, m1Rvalid}, {31'd0, rvPend[1]});
    checkOutput("m0_rdata", m0Rdata, held[0]);
    checkOutput("m1_rdata", m1Rdata, held[1]);
    if (!rstN) begin
      checkOutput("ram_we_in_reset", {31'd0, ramWe}, 32'd0);
      resetModel();
      return;
    end
    for (int q = 0; q < 2; q++) if (reqV[q]) waitCyc[q]++;
    newRv[0] = 0; newRv[1] = 0; newData = '0;
    if (mSlot) begin
      p = int'(mOwner);
      granted[p] = 1;
      mdlAcc[p]++;
      mLast = mOwner;
      if (waitCyc[p] - 1 > maxWait) maxWait = waitCyc[p] - 1;
      waitCyc[p] = 0;
      if (weV[p]) begin
        checkOutput("ram_we_store", {31'd0, ramWe}, {31'd0, strbV[p] != 4'h0});
        checkOutput("ram_a_store", {16'd0, ramA}, {16'd0, addrV[p]});
        for (int i = 0; i < 4; i++)
          if (strbV[p][i]) refMem[addrV[p]][8*i +: 8] = wdataV[p][8*i +: 8];
      end else begin
        checkOutput("ram_we_load", {31'd0, ramWe}, 32'd0);
        newRv[p] = 1;
        newData  = refMem[addrV[p]];
      end
      mSlot = 0;
    end else begin
      checkOutput("ram_we_idle", {31'd0, ramWe}, 32'd0);
      if (reqV[0] && reqV[1]) begin
        mOwner = !mLast; mSlot = 1; mdlConf++;
      end else if (reqV[0]) begin
        mOwner = 0; mSlot = 1;
      end else if (reqV[1]) begin
        mOwner = 1; mSlot = 1;
      end
    end
    for (int q = 0; q < 2; q++) begin
      rvPend[q] = newRv[q];
      if (newRv[q]) held[q] = newData;
    end
  endtask

  // Requesters see the grant and release their request just after the next rising edge
  task automatic runCycle();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (granted[p]) begin
        reqV[p] = 0;
        granted[p] = 0;
      end
    end
  endtask

  task automatic applyStimulus(input int p, input logic we, input logic [3:0] strb,
                               input logic [15:0] addr, input logic [31:0] wdata);
    reqV[p] = 1; weV[p] = we; strbV[p] = strb; addrV[p] = addr; wdataV[p] = wdata;
  endtask

  task automatic applyRandom(input int p);
    applyStimulus(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  16'($urandom_range(0, 63)), $urandom);
  endtask

  task automatic pokeMem(input logic [15:0] addr, input logic [31:0] data);
    pokeEn = 1; pokeAddr = addr; pokeData = data;
    refMem[addr] = data;
    runCycle();
    pokeEn = 0;
  endtask

  function automatic bit busy();
    return reqV[0] || reqV[1] || mSlot || rvPend[0] || rvPend[1];
  endfunction

  task automatic runUntilIdle(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      runCycle();
      n++;
    end
    if (busy()) checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int diffs;
    rstN = 0; pokeEn = 0; pokeAddr = '0; pokeData = '0;
    for (int p = 0; p < 2; p++) begin
      reqV[p] = 0; weV[p] = 0; strbV[p] = '0; addrV[p] = '0; wdataV[p] = '0;
    end
    for (int i = 0; i < 65536; i++) refMem[i] = {i[15:0], ~i[15:0]};
    maxWait = 0;
    resetModel();
    @(posedge clk);
    #1;

    // Reset held with a pending store: no grant and no write until release
    applyStimulus(0, 1'b1, 4'hF, 16'h0040, 32'h12345678);
    repeat (3) runCycle();
    rstN = 1;
    runUntilIdle(20);
    checkOutput("store_after_reset", tbMem[16'h0040], 32'h12345678);

    // Plain load
    pokeMem(16'h0010, 32'hDEADBEEF);
    applyStimulus(0, 1'b0, 4'h0, 16'h0010, 32'h0);
    runUntilIdle(20);
    checkOutput("load_deadbeef", m0Rdata, 32'hDEADBEEF);

    // Partial store from m1
    pokeMem(16'h0020, 32'h11223344);
    applyStimulus(1, 1'b1, 4'b0101, 16'h0020, 32'hAABBCCDD);
    runUntilIdle(20);
    checkOutput("partial_store", tbMem[16'h0020], 32'h11BB33DD);

    // Zero strobe store leaves memory untouched
    pokeMem(16'h0030, 32'hCAFEF00D);
    applyStimulus(0, 1'b1, 4'h0, 16'h0030, 32'hFFFFFFFF);
    runUntilIdle(20);
    checkOutput("zero_strobe", tbMem[16'h0030], 32'hCAFEF00D);

    // Continuous contention: both ports reissue loads as soon as they are served
    for (int c = 0; c < 24; c++) begin
      for (int p = 0; p < 2; p++)
        if (!reqV[p]) applyStimulus(p, 1'b0, 4'h0, 16'($urandom_range(0, 63)), 32'h0);
      runCycle();
    end
    runUntilIdle(20);

    // Reset landing on the ACCESS cycle of a store
    pokeMem(16'h0050, 32'h00000000);
    applyStimulus(0, 1'b1, 4'hF, 16'h0050, 32'h55AA55AA);
    runCycle();
    rstN = 0;
    runCycle();
    checkOutput("no_write_mid_reset", tbMem[16'h0050], 32'h00000000);
    rstN = 1;
    runUntilIdle(20);
    checkOutput("store_after_mid_reset", tbMem[16'h0050], 32'h55AA55AA);

    // Random traffic from both ports
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++)
        if (!reqV[p] && $urandom_range(0, 2) == 0) applyRandom(p);
      runCycle();
    end
    runUntilIdle(20);

    diffs = 0;
    for (int i = 0; i < 128; i++) if (tbMem[i] !== refMem[i]) diffs++;
    checkOutput("mem_words_differing", 32'(diffs), 32'd0);
    checkOutput("max_wait_within_3", {31'd0, maxWait <= 3}, 32'd1);

`ifdef DATA_RAM_ARB_PERF_EN
    checkOutput("perf_m0_acc", perfM0, 32'(mdlAcc[0]));
    checkOutput("perf_m1_acc", perfM1, 32'(mdlAcc[1]));
    checkOutput("perf_conflict", perfConf, 32'(mdlConf));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
